// File: rtl/nibble_mayor_acumulador.sv
// nibble_mayor_acumulador: running maximum of winning nibbles over a frame.
// Delivers max / sample count / partial flag through a valid/ready handshake.
// Optional feature: define NMA_INDICE_EN to add the nma_indice output
// (0-based position of the first occurrence of the maximum).
module nibble_mayor_acumulador #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             nma_valid,
  input  logic [3:0]       nma_dato,
  input  logic             nma_flush,
  output logic             nma_out_valid,
  input  logic             nma_out_ready,
  output logic [3:0]       nma_max,
  output logic [CNT_W-1:0] nma_cuenta,
  output logic             nma_parcial,
`ifdef NMA_INDICE_EN
  output logic [CNT_W-1:0] nma_indice,
`endif
  output logic [7:0]       nma_perdidos
);

  typedef enum logic [1:0] {IDLE, ACUM, ENTREGA} state_t;

  state_t           st;
  logic [3:0]       max_r;
  logic [CNT_W-1:0] cnt_r;
`ifdef NMA_INDICE_EN
  logic [CNT_W-1:0] idx_r;
  logic [CNT_W-1:0] acc_idx, lat_idx;
`endif

  logic [3:0]       acc_max, lat_max;
  logic [CNT_W-1:0] acc_cnt, lat_cnt;
  logic             new_gt, full, cierra;

  // Accumulator after folding in this cycle's sample, and the values to latch
  // if the frame closes now (sample included only when it is valid).
  always_comb begin
    new_gt  = nma_dato > max_r;
    acc_max = new_gt ? nma_dato : max_r;
    acc_cnt = cnt_r + CNT_W'(1);
    full    = nma_valid && (acc_cnt == CNT_W'(FRAME_LEN));
    cierra  = full || nma_flush;
    lat_max = nma_valid ? acc_max : max_r;
    lat_cnt = nma_valid ? acc_cnt : cnt_r;
`ifdef NMA_INDICE_EN
    acc_idx = new_gt ? cnt_r : idx_r;
    lat_idx = nma_valid ? acc_idx : idx_r;
`endif
  end

  // Frame FSM: accumulate, close on full frame or flush, hold until accepted.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      st            <= IDLE;
      max_r         <= '0;
      cnt_r         <= '0;
      nma_out_valid <= 1'b0;
      nma_max       <= '0;
      nma_cuenta    <= '0;
      nma_parcial   <= 1'b0;
      nma_perdidos  <= '0;
`ifdef NMA_INDICE_EN
      idx_r         <= '0;
      nma_indice    <= '0;
`endif
    end else begin
      case (st)
        IDLE: begin
          // A lone flush here is ignored: empty frames are never emitted.
          if (nma_valid) begin
            max_r <= nma_dato;
            cnt_r <= CNT_W'(1);
`ifdef NMA_INDICE_EN
            idx_r <= '0;
`endif
            st    <= ACUM;
          end
        end
        ACUM: begin
          if (cierra) begin
            nma_max       <= lat_max;
            nma_cuenta    <= lat_cnt;
            nma_parcial   <= !full;
`ifdef NMA_INDICE_EN
            nma_indice    <= lat_idx;
`endif
            nma_out_valid <= 1'b1;
            st            <= ENTREGA;
          end else if (nma_valid) begin
            max_r <= acc_max;
            cnt_r <= acc_cnt;
`ifdef NMA_INDICE_EN
            idx_r <= acc_idx;
`endif
          end
        end
        ENTREGA: begin
          if (nma_out_ready) begin
            nma_out_valid <= 1'b0;
            // A sample arriving with the acceptance opens the next frame.
            if (nma_valid) begin
              max_r <= nma_dato;
              cnt_r <= CNT_W'(1);
`ifdef NMA_INDICE_EN
              idx_r <= '0;
`endif
              st    <= ACUM;
            end else begin
              st <= IDLE;
            end
          end else if (nma_valid && (nma_perdidos != 8'hFF)) begin
            nma_perdidos <= nma_perdidos + 8'd1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_mayor_acumulador.sv
// Scoreboard bench for nibble_mayor_acumulador with FRAME_LEN=4.
module tb_nibble_mayor_acumulador;
  localparam int FL = 4;
  localparam int CW = 4;

  logic          clk, reset_L;
  logic          nma_valid, nma_flush, nma_out_ready;
  logic [3:0]    nma_dato;
  logic          nma_out_valid, nma_parcial;
  logic [3:0]    nma_max;
  logic [CW-1:0] nma_cuenta;
  logic [7:0]    nma_perdidos;
  logic [CW-1:0] nma_indice;

  nibble_mayor_acumulador #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
    .clk(clk), .reset_L(reset_L),
    .nma_valid(nma_valid), .nma_dato(nma_dato), .nma_flush(nma_flush),
    .nma_out_valid(nma_out_valid), .nma_out_ready(nma_out_ready),
    .nma_max(nma_max), .nma_cuenta(nma_cuenta), .nma_parcial(nma_parcial),
`ifdef NMA_INDICE_EN
    .nma_indice(nma_indice),
`endif
    .nma_perdidos(nma_perdidos)
  );

`ifndef NMA_INDICE_EN
  assign nma_indice = '0;
`endif

  typedef struct {
    logic [3:0]    mx;
    logic [CW-1:0] cnt;
    logic          parc;
    logic [CW-1:0] idx;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int mx, input int cnt, input int parc, input int idx);
    exp_t e;
    e.mx = 4'(mx); e.cnt = CW'(cnt); e.parc = parc[0]; e.idx = CW'(idx);
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs; returns just after the sampling edge.
  task automatic cyc(input logic v, input int d, input logic f, input logic r);
    nma_valid = v; nma_dato = 4'(d); nma_flush = f; nma_out_ready = r;
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"},    32'(nma_out_valid), 0);
    chk({tag, "_max"},      32'(nma_max),       0);
    chk({tag, "_cuenta"},   32'(nma_cuenta),    0);
    chk({tag, "_parcial"},  32'(nma_parcial),   0);
    chk({tag, "_perdidos"}, 32'(nma_perdidos),  0);
    chk({tag, "_indice"},   32'(nma_indice),    0);
  endtask

  // Result monitor: every cycle with out_valid must match the scoreboard head;
  // the head retires only when the handshake completes on the next edge.
  always @(negedge clk) begin
    if (reset_L && nma_out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(nma_out_valid), 0);
      end else begin
        chk("max",     32'(nma_max),     32'(sb[0].mx));
        chk("cuenta",  32'(nma_cuenta),  32'(sb[0].cnt));
        chk("parcial", 32'(nma_parcial), 32'(sb[0].parc));
`ifdef NMA_INDICE_EN
        chk("indice",  32'(nma_indice),  32'(sb[0].idx));
`endif
        if (nma_out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    reset_L = 1'b1; nma_valid = 0; nma_dato = 0; nma_flush = 0; nma_out_ready = 1;
    #2 reset_L = 1'b0;
    #1 chk_zero("reset");
    @(posedge clk); #1;
    reset_L = 1'b1;
    cyc(0, 0, 0, 1);

    // Full frame, ties keep first occurrence.
    push(9, 4, 0, 1);
    cyc(1, 3, 0, 1); cyc(1, 9, 0, 1); cyc(1, 9, 0, 1); cyc(1, 2, 0, 1);
    chk("full_valid_rise", 32'(nma_out_valid), 1);
    cyc(0, 0, 0, 1);
    chk("full_valid_one_cycle", 32'(nma_out_valid), 0);
    cyc(0, 0, 0, 1);

    // Early flush, then a flush in IDLE that must emit nothing.
    push(5, 2, 1, 0);
    cyc(1, 5, 0, 1); cyc(1, 1, 0, 1); cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    chk("idle_flush_no_out", 32'(nma_out_valid), 0);

    // Backpressure: result held while 3 samples are dropped.
    push(4, 4, 0, 3);
    cyc(1, 1, 0, 0); cyc(1, 2, 0, 0); cyc(1, 3, 0, 0); cyc(1, 4, 0, 0);
    cyc(1, 8, 0, 0); cyc(1, 8, 0, 0); cyc(1, 8, 0, 0);
    chk("perdidos_3", 32'(nma_perdidos), 3);
    cyc(0, 0, 0, 1);
    chk("accepted_idle", 32'(nma_out_valid), 0);
    cyc(0, 0, 0, 1);

    // Accept and start a new frame in the same cycle; no drops back-to-back.
    push(2, 4, 0, 0);
    push(7, 1, 1, 0);
    cyc(1, 2, 0, 1); cyc(1, 2, 0, 1); cyc(1, 2, 0, 1); cyc(1, 2, 0, 1);
    cyc(1, 7, 0, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    chk("b2b_no_drop", 32'(nma_perdidos), 3);
    cyc(0, 0, 0, 1);

    // Drop counter saturation.
    push(1, 4, 0, 0);
    cyc(1, 1, 0, 1); cyc(1, 1, 0, 1); cyc(1, 1, 0, 1); cyc(1, 1, 0, 1);
    for (int i = 0; i < 300; i++) cyc(1, 15, 0, 0);
    chk("perdidos_sat", 32'(nma_perdidos), 255);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    // Asynchronous reset mid-frame, between edges.
    cyc(1, 5, 0, 1); cyc(1, 6, 0, 1);
    nma_valid = 0; nma_dato = 0;
    #2 reset_L = 1'b0;
    #1 chk_zero("midreset");
    #2 reset_L = 1'b1;
    push(4, 4, 0, 3);
    cyc(1, 1, 0, 1); cyc(1, 2, 0, 1); cyc(1, 3, 0, 1); cyc(1, 4, 0, 1);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
